code_sequence_lock: RTL
=======================

Name: code_sequence_lock

Overview:
- Sequential successor to the board-level switch-code matcher.
- Accepts a secret code as NUM_DIGITS digits of DIGIT_W bits, entered one digit per `enter` pulse, and compares against a parameter code.
- Counts failed attempts and imposes a timed lockout.
- Sits between debounced KEY/SW inputs and the LEDR/HEX drivers in the board top level.

Parameters:
- DIGIT_W, 4, bits per digit.
- NUM_DIGITS, 2, digits per code; must be at least 1.
- CODE, 8'h84, packed secret code, width DIGIT_W*NUM_DIGITS. Digit 0 is bits [DIGIT_W-1:0] and is entered first.
- MAX_TRIES, 3, consecutive failed attempts before lockout; must be at least 1.
- LOCKOUT_CYCLES, 16, clock cycles spent in lockout; must be at least 1.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- digit_in, input, DIGIT_W, current digit value; sampled only when enter=1.
- enter, input, 1, single-cycle pulse (already debounced and edge-detected upstream); submits digit_in.
- clear, input, 1, single-cycle pulse; abandons a partial entry.
- relock, input, 1, single-cycle pulse; returns UNLOCKED to IDLE.
- unlocked, output, 1, high while in UNLOCKED.
- locked_out, output, 1, high while in LOCKOUT.
- fail_pulse, output, 1, one-cycle pulse on each failed attempt.
- digit_count, output, clog2(NUM_DIGITS+1), digits entered in the current attempt.
- tries_left, output, clog2(MAX_TRIES+1), attempts remaining before lockout.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State IDLE.
  - unlocked=0, locked_out=0, fail_pulse=0, digit_count=0, tries_left=MAX_TRIES.
  - Internal mismatch flag=0, lockout timer=0.
- All outputs are registered.
- States and transitions:
  - IDLE → ENTRY on enter. Sample digit_in against digit 0, set mismatch = (digit_in != CODE digit 0), digit_count=1.
  - ENTRY, on enter:
    - Compare digit_in with CODE digit[digit_count] and OR the result into mismatch.
    - Increment digit_count.
    - No per-digit correctness is revealed.
  - Final digit (enter when digit_count==NUM_DIGITS-1, including the NUM_DIGITS=1 case from IDLE), evaluated with mismatch including the final digit:
    - All digits matched: go to UNLOCKED next cycle, unlocked=1, tries_left reloads MAX_TRIES, digit_count=0.
    - Otherwise, tries_left>1: fail_pulse=1 for one cycle, tries_left decrements, go to IDLE, digit_count=0.
    - Otherwise, tries_left==1: fail_pulse=1, go to LOCKOUT, locked_out=1, timer loads LOCKOUT_CYCLES-1, tries_left=0.
  - ENTRY on clear: go to IDLE, digit_count=0, mismatch=0, tries_left unchanged (not a failure).
  - UNLOCKED: enter and clear ignored. On relock go to IDLE with unlocked=0.
  - LOCKOUT:
    - enter, clear and relock are all ignored.
    - Timer decrements each cycle.
    - When timer==0, next cycle: IDLE, locked_out=0, tries_left=MAX_TRIES.
    - locked_out is therefore high for exactly LOCKOUT_CYCLES cycles.
- Latency: unlocked, fail_pulse and locked_out assert on the clock edge that samples the final enter, so they are visible in the following cycle.
- Simultaneous events:
  - clear and enter in the same cycle in ENTRY or IDLE: clear wins and the digit is discarded.
  - relock in any state other than UNLOCKED is ignored.
- Wrap-around: digit_count never exceeds NUM_DIGITS-1 while in ENTRY; tries_left never underflows.
- Reset mid-entry or mid-lockout: immediately returns to reset values; the lockout is not resumed.

Test Plan:
- Defaults. Reset, then enter 4, then enter 8 → unlocked=1 in the cycle after the second enter; tries_left=3; fail_pulse never asserted.
- Enter 8 then 4 (wrong order) → fail_pulse high for exactly 1 cycle, tries_left=2, state IDLE, unlocked=0.
- Three wrong attempts (5,5 three times) → third attempt gives fail_pulse and locked_out=1 for exactly 16 cycles. Enters during lockout have no effect. Afterwards tries_left=3, and the sequence 4,8 unlocks.
- Enter 4, then clear, then 4, 8 → unlocked=1, tries_left still 3. Repeat with clear and enter together on the second digit → entry discarded, digit_count=0.
- While unlocked, enter and clear pulses → no change. Then relock → unlocked=0, IDLE. A single enter 4 → digit_count=1.
- Deassert reset_n asynchronously mid-lockout (cycle 7) and mid-entry (digit_count=1) → all outputs at reset values immediately, before the next clk edge. Also repeat with NUM_DIGITS=3, DIGIT_W=3, CODE=9'o725: enter 5,2,7 → unlocked.

Source files
------------

// File: rtl/code_sequence_lock_if.sv
// Keypad-side bundle for code_sequence_lock: digit/strobe inputs from the debounced
// keys, plus the status outputs that feed the LED/HEX drivers.
interface code_sequence_lock_if #(
  parameter int DIGIT_W    = 4,
  parameter int NUM_DIGITS = 2,
  parameter int MAX_TRIES  = 3
);
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);

  logic [DIGIT_W-1:0] digit_in;
  logic               enter;
  logic               clear;
  logic               relock;
  logic               unlocked;
  logic               locked_out;
  logic               fail_pulse;
  logic [CW-1:0]      digit_count;
  logic [TW-1:0]      tries_left;

  modport master (
    output digit_in, enter, clear, relock,
    input  unlocked, locked_out, fail_pulse, digit_count, tries_left
  );

  modport slave (
    input  digit_in, enter, clear, relock,
    output unlocked, locked_out, fail_pulse, digit_count, tries_left
  );
endinterface

// File: rtl/code_sequence_lock.sv
// Sequential code lock: digits arrive one per enter pulse, are compared against CODE,
// and repeated failures trigger a timed lockout.
module code_sequence_lock #(
  parameter int                            DIGIT_W        = 4,
  parameter int                            NUM_DIGITS     = 2,
  parameter logic [DIGIT_W*NUM_DIGITS-1:0] CODE           = 8'h84,
  parameter int                            MAX_TRIES      = 3,
  parameter int                            LOCKOUT_CYCLES = 16
) (
  input logic                clk,
  input logic                reset_n,
  code_sequence_lock_if.slave bus
);
  localparam int CW    = $clog2(NUM_DIGITS + 1);
  localparam int TW    = $clog2(MAX_TRIES + 1);
  localparam int TMR_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  localparam logic [CW-1:0]    LAST_IDX = CW'(NUM_DIGITS - 1);
  localparam logic [TW-1:0]    MAX_T    = TW'(MAX_TRIES);
  localparam logic [TMR_W-1:0] LOAD_T   = TMR_W'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ENTRY, UNLOCKED, LOCKOUT} state_t;

  state_t             state;
  logic               mismatch;
  logic [TMR_W-1:0]   timer;
  logic [CW-1:0]      dcount;
  logic [TW-1:0]      tries;
  logic               unl;
  logic               lko;
  logic               fpl;

  logic [CW-1:0]      sel;
  logic [DIGIT_W-1:0] code_dig;
  logic               mm_next;
  logic               last;

  // In IDLE the incoming digit is always digit 0, so the same compare path covers
  // both the first digit and the NUM_DIGITS==1 case.
  always_comb begin
    sel      = (state == ENTRY) ? dcount : '0;
    code_dig = DIGIT_W'(CODE >> (int'(sel) * DIGIT_W));
    mm_next  = ((state == ENTRY) && mismatch) || (bus.digit_in != code_dig);
    last     = (sel == LAST_IDX);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      mismatch <= 1'b0;
      timer    <= '0;
      dcount   <= '0;
      tries    <= MAX_T;
      unl      <= 1'b0;
      lko      <= 1'b0;
      fpl      <= 1'b0;
    end else begin
      fpl <= 1'b0;
      case (state)
        IDLE, ENTRY: begin
          if (bus.clear) begin
            state    <= IDLE;
            dcount   <= '0;
            mismatch <= 1'b0;
          end else if (bus.enter) begin
            if (!last) begin
              state    <= ENTRY;
              dcount   <= dcount + 1'b1;
              mismatch <= mm_next;
            end else begin
              dcount   <= '0;
              mismatch <= 1'b0;
              if (!mm_next) begin
                state <= UNLOCKED;
                unl   <= 1'b1;
                tries <= MAX_T;
              end else if (tries > TW'(1)) begin
                state <= IDLE;
                fpl   <= 1'b1;
                tries <= tries - 1'b1;
              end else begin
                state <= LOCKOUT;
                fpl   <= 1'b1;
                lko   <= 1'b1;
                timer <= LOAD_T;
                tries <= '0;
              end
            end
          end
        end
        UNLOCKED: begin
          if (bus.relock) begin
            state <= IDLE;
            unl   <= 1'b0;
          end
        end
        LOCKOUT: begin
          // Timer reaching zero still spends one cycle here, giving LOCKOUT_CYCLES high.
          if (timer == '0) begin
            state <= IDLE;
            lko   <= 1'b0;
            tries <= MAX_T;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.unlocked    = unl;
  assign bus.locked_out  = lko;
  assign bus.fail_pulse  = fpl;
  assign bus.digit_count = dcount;
  assign bus.tries_left  = tries;
endmodule
